fetch_pc_predictor: RTL

Parametrised program-counter generator for the fetch stage of the 5-stage RISC-V pipeline. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch follows predicted-taken branches without waiting for execute. Execute resolves each branch, trains the BTB, and issues an explicit redirect on misprediction; that redirect is the recovery path. Sits between the top-level control (cpu_en, stall) and instruction memory / IF-ID register.

---
 rtl/fetch_pc_predictor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC generator with an optional direct-mapped BTB of 2-bit counters.
// Define FETCH_BTB_EN to build the BTB; otherwise fetch is static not-taken.
module fetch_pc_predictor #(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  BTB_DEPTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic                is_stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target
);

  logic [PC_WIDTH-1:0] pc_plus4;
  assign pc_plus4 = pc + PC_WIDTH'(4);

  // Redirect beats stall; the predicted next PC is followed otherwise.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (cpu_en) begin
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (!is_stall) begin
        pc <= pred_target;
      end
    end
  end

`ifdef FETCH_BTB_EN

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [PC_WIDTH-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

  localparam btb_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

  btb_entry_t       btb [BTB_DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  btb_entry_t       rd_entry;
  btb_entry_t       wr_old;
  btb_entry_t       wr_entry;
  logic             upd_hit;
  logic             wr_en;
  logic             unused_upd_lsb;

  assign unused_upd_lsb = ^upd_pc[1:0];

  assign rd_idx   = pc[IDX_W+1:2];
  assign rd_tag   = pc[PC_WIDTH-1:IDX_W+2];
  assign wr_idx   = upd_pc[IDX_W+1:2];
  assign wr_tag   = upd_pc[PC_WIDTH-1:IDX_W+2];
  assign rd_entry = btb[rd_idx];
  assign wr_old   = btb[wr_idx];
  assign upd_hit  = wr_old.valid && (wr_old.tag == wr_tag);

  assign pred_taken  = rd_entry.valid && (rd_entry.tag == rd_tag) && rd_entry.ctr[1];
  assign pred_target = pred_taken ? rd_entry.target : pc_plus4;

  // Training: saturating counter on a hit, allocate weakly-taken on a taken miss.
  always_comb begin
    wr_en          = 1'b0;
    wr_entry       = wr_old;
    wr_entry.valid = 1'b1;
    wr_entry.tag   = wr_tag;
    if (cpu_en && upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_entry.target = upd_target;
          if (wr_old.ctr != 2'b11) wr_entry.ctr = wr_old.ctr + 2'b01;
        end else if (wr_old.ctr != 2'b00) begin
          wr_entry.ctr = wr_old.ctr - 2'b01;
        end
      end else if (upd_taken) begin
        wr_en           = 1'b1;
        wr_entry.target = upd_target;
        wr_entry.ctr    = 2'b10;
      end
    end
  end

  // NOTE: the table is built from flops, not RAM, because reset must clear every entry at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb[i] <= ENTRY_RESET;
    end else if (wr_en) begin
      btb[wr_idx] <= wr_entry;
    end
  end

`else

  logic unused_upd;
  assign unused_upd  = ^{upd_valid, upd_pc, upd_taken, upd_target};
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;

`endif

endmodule
